// File: rtl/line_buffer_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_3x3
//  Description : Streaming 3x3 sliding-window generator (valid mode, no
//                padding) built from two row line buffers and a 3x3 register
//                window. Optional macro WIN_STRIDE2_EN emits only windows
//                whose bottom-right pixel sits on an even row and even column.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_3x3 #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pixel_in,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic [DATA_W-1:0] data_out4,
    output logic [DATA_W-1:0] data_out5,
    output logic [DATA_W-1:0] data_out6,
    output logic [DATA_W-1:0] data_out7,
    output logic [DATA_W-1:0] data_out8,
    output logic              valid_out,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_lb0 [IMG_W];   // row r-1
    logic [DATA_W-1:0] r_lb1 [IMG_W];   // row r-2
    logic [DATA_W-1:0] r_win [9];
    logic              r_valid_out;
    logic              r_frame_done;

    logic              w_col_last;
    logic              w_row_last;
    logic              w_qual;
    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;

    assign w_col_last = (r_col == C_COL_LAST);
    assign w_row_last = (r_row == C_ROW_LAST);
    assign w_lb0_rd   = r_lb0[r_col];
    assign w_lb1_rd   = r_lb1[r_col];

`ifdef WIN_STRIDE2_EN
    assign w_qual = valid_in && (r_row >= RW'(2)) && (r_col >= CW'(2))
                    && !r_row[0] && !r_col[0];
`else
    assign w_qual = valid_in && (r_row >= RW'(2)) && (r_col >= CW'(2));
`endif

    // Line-buffer storage carries no reset; stale contents are never exposed
    // because windows are only flagged once two full rows have been written.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_valid_out  <= w_qual;
            r_frame_done <= valid_in && w_col_last && w_row_last;
            if (valid_in) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb1_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb0_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pixel_in;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign data_out0  = r_win[0];
    assign data_out1  = r_win[1];
    assign data_out2  = r_win[2];
    assign data_out3  = r_win[3];
    assign data_out4  = r_win[4];
    assign data_out5  = r_win[5];
    assign data_out6  = r_win[6];
    assign data_out7  = r_win[7];
    assign data_out8  = r_win[8];
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
